// File: rtl/exch9_pkg.sv
// exch9_pkg: shared state enum, widths and default source words for the 9-bit exchange
package exch9_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  localparam int EXCH9_W = 9;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(EXCH9_W - 1);
  localparam logic [EXCH9_W-1:0] MASTER_WORD = 9'h17A;
  localparam logic [EXCH9_W-1:0] SLAVE_WORD = 9'h1DB;
endpackage

// File: rtl/exch9_sclk_gen.sv
// exch9_sclk_gen: sclk divider (in clk, rst, en, clr; out sclk idling low, rise/fall pulses high in the clk cycle whose edge toggles sclk)
module exch9_sclk_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic sclk,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] cnt;
  logic wrap;
  assign wrap = en && cnt == LAST;
  assign rise = wrap && !sclk;
  assign fall = wrap && sclk;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (en) begin
      cnt  <= wrap ? '0 : cnt + 1'b1;
      sclk <= wrap ? ~sclk : sclk;
    end
  end
endmodule

// File: rtl/exch9_ctrl.sv
// exch9_ctrl: full-duplex 9-bit exchange sequencer (in clk, rst, st, master_dat, slave_dat; out sclk, mosi, miso, busy, done, master_rx, slave_rx; EXCH9_LSB_FIRST_EN selects LSB-first line order)
module exch9_ctrl
  import exch9_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st,
  input  logic [EXCH9_W-1:0] master_dat,
  input  logic [EXCH9_W-1:0] slave_dat,
  output logic               sclk,
  output logic               mosi,
  output logic               miso,
  output logic               busy,
  output logic               done,
  output logic [EXCH9_W-1:0] master_rx,
  output logic [EXCH9_W-1:0] slave_rx
);
  state_t state, nxt;
  logic [EXCH9_W-1:0] master_sr, slave_sr, m_nxt, s_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic m_in, s_in, rise, fall;
  exch9_sclk_gen #(.DIV(DIV)) u_sclk (
    .clk (clk),
    .rst (rst),
    .en  (state == SHIFT),
    .clr (state == LOAD),
    .sclk(sclk),
    .rise(rise),
    .fall(fall)
  );
`ifdef EXCH9_LSB_FIRST_EN
  assign mosi  = master_sr[0];
  assign miso  = slave_sr[0];
  assign m_nxt = {m_in, master_sr[EXCH9_W-1:1]};
  assign s_nxt = {s_in, slave_sr[EXCH9_W-1:1]};
`else
  assign mosi  = master_sr[EXCH9_W-1];
  assign miso  = slave_sr[EXCH9_W-1];
  assign m_nxt = {master_sr[EXCH9_W-2:0], m_in};
  assign s_nxt = {slave_sr[EXCH9_W-2:0], s_in};
`endif
  assign master_rx = master_sr;
  assign slave_rx  = slave_sr;
  assign busy      = state == LOAD || state == SHIFT;
  assign done      = state == DONE;
  always_comb begin
    nxt = state;
    nxt = state == IDLE  ? (st ? LOAD : IDLE) :
          state == LOAD  ? SHIFT :
          state == SHIFT ? ((fall && bit_cnt == LAST_BIT) ? DONE : SHIFT) :
                           IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      master_sr <= '0;
      slave_sr  <= '0;
      m_in      <= 1'b0;
      s_in      <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == LOAD) begin
        master_sr <= master_dat;
        slave_sr  <= slave_dat;
        bit_cnt   <= '0;
      end
      if (rise) begin
        m_in <= miso;
        s_in <= mosi;
      end
      if (fall) begin
        master_sr <= m_nxt;
        slave_sr  <= s_nxt;
        bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_exch9_ctrl.sv
// tb_exch9_ctrl: directed table-driven bench for exch9_ctrl at DIV=1 and DIV=4
module tb_exch9_ctrl;
  import exch9_pkg::*;
  logic clk = 1'b0, rst = 1'b1, st1 = 1'b0, st4 = 1'b0;
  logic [8:0] mdat = '0, sdat = '0;
  logic sclk1, mosi1, miso1, busy1, done1, sclk4, mosi4, miso4, busy4, done4;
  logic [8:0] mrx1, srx1, mrx4, srx4;
  int tests = 0, fails = 0;
  typedef struct {
    logic       u4;
    logic [8:0] m;
    logic [8:0] s;
    int         dcyc;
  } vec_t;
  vec_t tbl[6];
  always #5 clk = ~clk;
  exch9_ctrl #(.DIV(1)) d1 (
    .clk(clk), .rst(rst), .st(st1), .master_dat(mdat), .slave_dat(sdat),
    .sclk(sclk1), .mosi(mosi1), .miso(miso1), .busy(busy1), .done(done1),
    .master_rx(mrx1), .slave_rx(srx1)
  );
  exch9_ctrl #(.DIV(4)) d4 (
    .clk(clk), .rst(rst), .st(st4), .master_dat(mdat), .slave_dat(sdat),
    .sclk(sclk4), .mosi(mosi4), .miso(miso4), .busy(busy4), .done(done4),
    .master_rx(mrx4), .slave_rx(srx4)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [8:0] line_order(input logic [8:0] w);
    logic [8:0] r;
`ifdef EXCH9_LSB_FIRST_EN
    for (int i = 0; i < 9; i++) r[i] = w[8-i];
`else
    r = w;
`endif
    return r;
  endfunction
  task automatic run(input logic u4, input logic [8:0] m, input logic [8:0] s,
                     output int dcyc, output int pulses, output logic [8:0] mseq,
                     output logic [8:0] sseq, output logic b1, output logic bd);
    logic prev, sc;
    mdat = m;
    sdat = s;
    @(negedge clk);
    if (u4) st4 = 1'b1; else st1 = 1'b1;
    @(posedge clk);
    dcyc = -1; pulses = 0; mseq = '0; sseq = '0; prev = 1'b0; b1 = 1'b0; bd = 1'b1;
    for (int n = 1; n <= 200 && dcyc < 0; n++) begin
      @(negedge clk);
      st1 = 1'b0;
      st4 = 1'b0;
      sc = u4 ? sclk4 : sclk1;
      if (n == 1) b1 = u4 ? busy4 : busy1;
      if (sc && !prev) begin
        pulses++;
        mseq = {mseq[7:0], u4 ? mosi4 : mosi1};
        sseq = {sseq[7:0], u4 ? miso4 : miso1};
      end
      prev = sc;
      if (u4 ? done4 : done1) begin
        dcyc = n;
        bd = u4 ? busy4 : busy1;
      end
    end
    @(negedge clk);
  endtask
  initial begin
    int dc, np, dcnt, rcnt;
    int dcs[2], rcs[2];
    logic [8:0] ms, ss;
    logic b1, bd, pb, seen;
    tbl[0] = '{1'b0, MASTER_WORD, SLAVE_WORD, 20};
    tbl[1] = '{1'b0, 9'h000, 9'h1FF, 20};
    tbl[2] = '{1'b0, 9'h155, 9'h0AA, 20};
    tbl[3] = '{1'b0, 9'h1FF, 9'h1FF, 20};
    tbl[4] = '{1'b0, 9'h001, 9'h100, 20};
    tbl[5] = '{1'b1, MASTER_WORD, SLAVE_WORD, 74};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_d1", {sclk1, mosi1, miso1, busy1, done1, mrx1, srx1}, 0);
    chk("reset_d4", {sclk4, mosi4, miso4, busy4, done4, mrx4, srx4}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_d1", {sclk1, busy1, done1, mrx1}, 0);
    run(1'b0, MASTER_WORD, SLAVE_WORD, dc, np, ms, ss, b1, bd);
`ifdef EXCH9_LSB_FIRST_EN
    chk("mosi_seq_const", ms, 9'b010111101);
    chk("miso_seq_const", ss, 9'b110110111);
`else
    chk("mosi_seq_const", ms, 9'b101111010);
    chk("miso_seq_const", ss, 9'b111011011);
`endif
    for (int i = 0; i < 6; i++) begin
      run(tbl[i].u4, tbl[i].m, tbl[i].s, dc, np, ms, ss, b1, bd);
      chk($sformatf("done_cycle[%0d]", i), dc, tbl[i].dcyc);
      chk($sformatf("pulses[%0d]", i), np, 9);
      chk($sformatf("master_rx[%0d]", i), tbl[i].u4 ? mrx4 : mrx1, tbl[i].s);
      chk($sformatf("slave_rx[%0d]", i), tbl[i].u4 ? srx4 : srx1, tbl[i].m);
      chk($sformatf("mosi_seq[%0d]", i), ms, line_order(tbl[i].m));
      chk($sformatf("miso_seq[%0d]", i), ss, line_order(tbl[i].s));
      chk($sformatf("busy_load[%0d]", i), b1, 1);
      chk($sformatf("busy_done[%0d]", i), bd, 0);
      chk($sformatf("sclk_idle[%0d]", i), tbl[i].u4 ? sclk4 : sclk1, 0);
    end
    // st held high for 100 cycles on DIV=4; sources swapped after the first LOAD
    mdat = MASTER_WORD;
    sdat = SLAVE_WORD;
    @(negedge clk);
    st4 = 1'b1;
    @(posedge clk);
    dcnt = 0; rcnt = 0; pb = 1'b0; dcs = '{-1, -1}; rcs = '{-1, -1};
    for (int n = 1; n <= 160; n++) begin
      @(negedge clk);
      if (n == 3) begin
        mdat = SLAVE_WORD;
        sdat = MASTER_WORD;
      end
      if (n == 100) st4 = 1'b0;
      if (busy4 && !pb) begin
        if (rcnt < 2) rcs[rcnt] = n;
        rcnt++;
      end
      pb = busy4;
      if (done4) begin
        if (dcnt < 2) dcs[dcnt] = n;
        dcnt++;
      end
      if (n == 75) begin
        chk("capture_mrx_first", mrx4, SLAVE_WORD);
        chk("capture_srx_first", srx4, MASTER_WORD);
      end
    end
    chk("hold_done_count", dcnt, 2);
    chk("hold_start_count", rcnt, 2);
    chk("hold_done0", dcs[0], 74);
    chk("hold_done1", dcs[1], 149);
    chk("hold_busy_rise0", rcs[0], 1);
    chk("hold_busy_rise1", rcs[1], 76);
    chk("swapped_back_mrx", mrx4, MASTER_WORD);
    chk("swapped_back_srx", srx4, SLAVE_WORD);
    // reset in the middle of a DIV=1 exchange
    mdat = MASTER_WORD;
    sdat = SLAVE_WORD;
    @(negedge clk);
    st1 = 1'b1;
    @(posedge clk);
    seen = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      st1 = 1'b0;
      seen = seen | done1;
    end
    chk("busy_before_rst", busy1, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_midop_outputs", {sclk1, mosi1, miso1, busy1, done1, mrx1, srx1}, 0);
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      seen = seen | done1;
    end
    chk("rst_no_done", seen, 0);
    run(1'b0, MASTER_WORD, SLAVE_WORD, dc, np, ms, ss, b1, bd);
    chk("post_rst_done", dc, 20);
    chk("post_rst_pulses", np, 9);
    chk("post_rst_mrx", mrx1, SLAVE_WORD);
    chk("post_rst_srx", srx1, MASTER_WORD);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
